// File: rtl/vdp_vcnt_ctrl_if.sv
// Vertical counter controller bus: line strobe and mode inputs in, counter and
// frame timing flags out. The master drives the inputs and the slave is the controller.
interface vdp_vcnt_ctrl_if;
  logic       HEND;
  logic       PAL;
  logic       M5;
  logic       V30;
  logic       LS0;
  logic       VINT_ACK;
  logic [8:0] VCNT;
  logic       ODD_EVEN;
  logic       VBLANK;
  logic       VSYNC;
  logic       VINT_PEND;
  logic       FRAME_END;

  modport master (
    output HEND, PAL, M5, V30, LS0, VINT_ACK,
    input  VCNT, ODD_EVEN, VBLANK, VSYNC, VINT_PEND, FRAME_END
  );

  modport slave (
    input  HEND, PAL, M5, V30, LS0, VINT_ACK,
    output VCNT, ODD_EVEN, VBLANK, VSYNC, VINT_PEND, FRAME_END
  );
endinterface

// File: rtl/vdp_vcnt_ctrl.sv
// VDP vertical line counter with blanking, sync, interrupt and interlace field control.
// Optional macro VDP_VCNT_V30_EN builds the PAL mode 5 240-line timing.
module vdp_vcnt_ctrl #(
  parameter int VSYNC_LINES = 3
) (
  input  logic            MCLK,
  input  logic            RES_n,
  vdp_vcnt_ctrl_if.slave  bus
);

  typedef enum logic [1:0] {ACTIVE, BOTTOM, TOP} state_e;

  localparam logic [3:0] VS_INIT = 4'(VSYNC_LINES);

  state_e     state_q, state_d;
  logic [8:0] vcnt_q, vcnt_d;
  logic [8:0] src, tgt, height;
  logic       pal_q, m5_q, ls0_q, first_q;
  logic       odd_q, vblank_q, vsync_q, vint_q, fend_q;
  logic [3:0] vs_cnt_q;
  logic       wrap, jump, vb_rise, vb_fall, latch;

`ifdef VDP_VCNT_V30_EN
  logic v30_q;
`else
  logic unused_v30;
  assign unused_v30 = bus.V30;
`endif

  // Jump points and active height come only from the modes latched at frame start.
  always_comb begin
    height = 9'h0C0;
    src    = 9'h0DA;
    tgt    = 9'h1D5;
    if (!pal_q && m5_q) begin
      height = 9'h0E0;
      src    = 9'h0EA;
      tgt    = 9'h1E5;
    end else if (pal_q && !m5_q) begin
      src    = 9'h0F2;
      tgt    = 9'h1BA;
    end else if (pal_q && m5_q) begin
      height = 9'h0E0;
      src    = 9'h102;
      tgt    = 9'h1CA;
`ifdef VDP_VCNT_V30_EN
      if (v30_q) begin
        height = 9'h0F0;
        src    = 9'h10A;
        tgt    = 9'h1D2;
      end
`endif
    end
    if (ls0_q && odd_q) tgt = tgt - 9'd1;
  end

  assign wrap  = (vcnt_q == 9'h1FF);
  assign jump  = (vcnt_q == src);
  assign latch = bus.HEND && (first_q || wrap);

  always_comb begin
    vcnt_d  = vcnt_q;
    state_d = state_q;
    if (bus.HEND) begin
      vcnt_d = jump ? tgt : vcnt_q + 9'd1;
      case (state_q)
        ACTIVE:  if (vcnt_d == height) state_d = BOTTOM;
        BOTTOM:  if (jump)             state_d = TOP;
        TOP:     if (wrap)             state_d = ACTIVE;
        default:                       state_d = ACTIVE;
      endcase
    end
  end

  assign vb_rise = (state_q == ACTIVE) && (state_d == BOTTOM);
  assign vb_fall = (state_q == TOP)    && (state_d == ACTIVE);

  always_ff @(posedge MCLK or negedge RES_n) begin
    if (!RES_n) begin
      state_q  <= ACTIVE;
      vcnt_q   <= '0;
      pal_q    <= 1'b0;
      m5_q     <= 1'b0;
      ls0_q    <= 1'b0;
      first_q  <= 1'b1;
      odd_q    <= 1'b0;
      vblank_q <= 1'b0;
      vsync_q  <= 1'b0;
      vs_cnt_q <= '0;
      vint_q   <= 1'b0;
      fend_q   <= 1'b0;
`ifdef VDP_VCNT_V30_EN
      v30_q    <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      vcnt_q  <= vcnt_d;
      fend_q  <= bus.HEND && wrap;
      if (latch) begin
        first_q <= 1'b0;
        pal_q   <= bus.PAL;
        m5_q    <= bus.M5;
        ls0_q   <= bus.LS0;
`ifdef VDP_VCNT_V30_EN
        v30_q   <= bus.V30;
`endif
      end
      // Field flag follows the interlace setting chosen for the frame being entered.
      if (bus.HEND && wrap) odd_q <= bus.LS0 ? ~odd_q : 1'b0;
      if (vb_rise)      vblank_q <= 1'b1;
      else if (vb_fall) vblank_q <= 1'b0;
      if (vb_rise)           vint_q <= 1'b1;
      else if (bus.VINT_ACK) vint_q <= 1'b0;
      if (bus.HEND) begin
        if (jump) begin
          vsync_q  <= 1'b1;
          vs_cnt_q <= VS_INIT;
        end else if (vsync_q) begin
          vs_cnt_q <= vs_cnt_q - 4'd1;
          if (vs_cnt_q == 4'd1) vsync_q <= 1'b0;
        end
      end
    end
  end

  assign bus.VCNT      = vcnt_q;
  assign bus.ODD_EVEN  = odd_q;
  assign bus.VBLANK    = vblank_q;
  assign bus.VSYNC     = vsync_q;
  assign bus.VINT_PEND = vint_q;
  assign bus.FRAME_END = fend_q;

endmodule

// File: tb/tb_vdp_vcnt_ctrl.sv
// Bench for vdp_vcnt_ctrl: frame-table vectors, hand corner sequences and a
// randomized run against a whole-frame line-sequence reference model.
module tb_vdp_vcnt_ctrl;
  localparam int VSL = 8;

  logic MCLK  = 1'b0;
  logic RES_n = 1'b1;

  vdp_vcnt_ctrl_if bus();
  vdp_vcnt_ctrl #(.VSYNC_LINES(VSL)) dut (.MCLK(MCLK), .RES_n(RES_n), .bus(bus));

  always #5 MCLK = ~MCLK;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model: the full VCNT sequence of the current frame plus a position in it.
  int seq[$];
  int idx, jidx, hgt;
  bit m_first, m_pal, m_m5, m_v30, m_ls0, m_odd, m_vblank, m_vint, m_fend;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic void build_frame();
    int s, t;
    if (!m_pal) begin
      s = m_m5 ? 'h0EA : 'h0DA;
      t = m_m5 ? 'h1E5 : 'h1D5;
    end else if (!m_m5) begin
      s = 'h0F2; t = 'h1BA;
    end else if (m_v30) begin
      s = 'h10A; t = 'h1D2;
    end else begin
      s = 'h102; t = 'h1CA;
    end
    hgt = !m_m5 ? 'h0C0 : (m_pal && m_v30) ? 'h0F0 : 'h0E0;
    if (m_ls0 && m_odd) t = t - 1;
    seq.delete();
    for (int v = 0; v <= s; v++) seq.push_back(v);
    jidx = seq.size();
    for (int v = t; v <= 'h1FF; v++) seq.push_back(v);
  endfunction

  function automatic void latch_modes();
    m_pal = bus.PAL;
    m_m5  = bus.M5;
    m_ls0 = bus.LS0;
`ifdef VDP_VCNT_V30_EN
    m_v30 = bus.V30;
`else
    m_v30 = 1'b0;
`endif
  endfunction

  function automatic void model_reset();
    m_first = 1; m_pal = 0; m_m5 = 0; m_v30 = 0; m_ls0 = 0;
    m_odd = 0; m_vblank = 0; m_vint = 0; m_fend = 0; idx = 0;
    build_frame();
  endfunction

  function automatic void model_edge(input bit hend, input bit ack);
    bit rise, nvb;
    rise   = 0;
    m_fend = 0;
    if (hend) begin
      if (m_first) begin
        m_first = 0;
        latch_modes();
        build_frame();
      end
      idx++;
      if (idx == seq.size()) begin
        idx    = 0;
        m_fend = 1;
        latch_modes();
        m_odd = m_ls0 ? !m_odd : 1'b0;
        build_frame();
      end
      nvb      = (seq[idx] >= hgt);
      rise     = nvb && !m_vblank;
      m_vblank = nvb;
    end
    if (rise)     m_vint = 1;
    else if (ack) m_vint = 0;
  endfunction

  task automatic cmp_all();
    chk("VCNT",      bus.VCNT,      seq[idx]);
    chk("ODD_EVEN",  bus.ODD_EVEN,  m_odd);
    chk("VBLANK",    bus.VBLANK,    m_vblank);
    chk("VSYNC",     bus.VSYNC,     (idx >= jidx) && (idx < jidx + VSL));
    chk("VINT_PEND", bus.VINT_PEND, m_vint);
    chk("FRAME_END", bus.FRAME_END, m_fend);
  endtask

  task automatic step(input bit hend, input bit ack);
    bus.HEND     = hend;
    bus.VINT_ACK = ack;
    @(posedge MCLK);
    #1;
    model_edge(hend, ack);
    cmp_all();
    bus.HEND     = 1'b0;
    bus.VINT_ACK = 1'b0;
  endtask

  // Asynchronous reset: outputs must clear before any MCLK edge arrives.
  task automatic do_reset();
    #2 RES_n = 1'b0;
    #1;
    chk("rst_VCNT",      bus.VCNT,      9'h000);
    chk("rst_VSYNC",     bus.VSYNC,     1'b0);
    chk("rst_VBLANK",    bus.VBLANK,    1'b0);
    chk("rst_VINT_PEND", bus.VINT_PEND, 1'b0);
    chk("rst_ODD_EVEN",  bus.ODD_EVEN,  1'b0);
    chk("rst_FRAME_END", bus.FRAME_END, 1'b0);
    model_reset();
    repeat (2) @(posedge MCLK);
    #5 RES_n = 1'b1;
  endtask

  task automatic measure(input int pal_at, output int len, output int src,
                         output int tgt, output int vbv);
    int prev;
    bit pvb;
    len = 0; src = -1; tgt = -1; vbv = -1;
    prev = int'(bus.VCNT);
    pvb  = bus.VBLANK;
    for (int i = 0; i < 400; i++) begin
      if (pal_at >= 0 && int'(bus.VCNT) == pal_at) bus.PAL = 1'b1;
      step(1, 0);
      len++;
      if (int'(bus.VCNT) != prev + 1 && bus.VCNT != 9'h000) begin
        src = prev;
        tgt = int'(bus.VCNT);
      end
      if (bus.VBLANK && !pvb) vbv = int'(bus.VCNT);
      pvb  = bus.VBLANK;
      prev = int'(bus.VCNT);
      if (bus.FRAME_END) break;
    end
  endtask

  task automatic set_mode(input bit pal, input bit m5, input bit v30, input bit ls0);
    bus.PAL = pal; bus.M5 = m5; bus.V30 = v30; bus.LS0 = ls0;
  endtask

  typedef struct {
    bit pal, m5, v30, ls0;
    int src, tgt, hgt, len;
  } vec_t;

  initial begin
    vec_t vt[6];
    int len, src, tgt, vbv;
    bit hit;

    vt[0] = '{0, 0, 0, 0, 'h0DA, 'h1D5, 'h0C0, 262};
    vt[1] = '{0, 1, 0, 0, 'h0EA, 'h1E5, 'h0E0, 262};
    vt[2] = '{1, 0, 0, 0, 'h0F2, 'h1BA, 'h0C0, 313};
    vt[3] = '{1, 1, 0, 0, 'h102, 'h1CA, 'h0E0, 313};
`ifdef VDP_VCNT_V30_EN
    vt[4] = '{1, 1, 1, 0, 'h10A, 'h1D2, 'h0F0, 313};
`else
    vt[4] = '{1, 1, 1, 0, 'h102, 'h1CA, 'h0E0, 313};
`endif
    vt[5] = '{0, 1, 1, 0, 'h0EA, 'h1E5, 'h0E0, 262};

    bus.HEND = 0; bus.VINT_ACK = 0;
    set_mode(0, 0, 0, 0);
    do_reset();

    foreach (vt[i]) begin
      set_mode(vt[i].pal, vt[i].m5, vt[i].v30, vt[i].ls0);
      do_reset();
      measure(-1, len, src, tgt, vbv);
      chk($sformatf("tbl%0d_len", i), len, vt[i].len);
      chk($sformatf("tbl%0d_src", i), src, vt[i].src);
      chk($sformatf("tbl%0d_tgt", i), tgt, vt[i].tgt);
      chk($sformatf("tbl%0d_vblank_at", i), vbv, vt[i].hgt);
    end

    // Interlace: even field 262 lines, odd field 263 lines with target one lower.
    set_mode(0, 1, 0, 1);
    do_reset();
    measure(-1, len, src, tgt, vbv);
    chk("il_f0_len", len, 262);
    chk("il_f0_odd", bus.ODD_EVEN, 1'b1);
    measure(-1, len, src, tgt, vbv);
    chk("il_f1_len", len, 263);
    chk("il_f1_tgt", tgt, 'h1E4);
    chk("il_f1_odd", bus.ODD_EVEN, 1'b0);

    // Mid-frame PAL change only takes effect from the next frame.
    set_mode(0, 0, 0, 0);
    do_reset();
    measure('h050, len, src, tgt, vbv);
    chk("pal_chg_cur_len", len, 262);
    measure(-1, len, src, tgt, vbv);
    chk("pal_chg_next_len", len, 313);

    // Ack coinciding with the interrupt set loses; a later ack clears it.
    set_mode(0, 1, 0, 0);
    do_reset();
    hit = 0;
    for (int i = 0; i < 400 && !hit; i++) begin
      if (bus.VCNT == 9'h0DF) hit = 1;
      else step(1, 0);
    end
    chk("ack_reach_0DF", hit, 1'b1);
    step(1, 1);
    chk("ack_coincide_pend", bus.VINT_PEND, 1'b1);
    step(0, 0);
    chk("ack_hold_pend", bus.VINT_PEND, 1'b1);
    step(0, 1);
    chk("ack_late_pend", bus.VINT_PEND, 1'b0);

    // Reset in the middle of VSYNC.
    hit = 0;
    for (int i = 0; i < 400 && !hit; i++) begin
      if (bus.VCNT == 9'h1E8) hit = 1;
      else step(1, 0);
    end
    chk("vs_reach_1E8", hit, 1'b1);
    chk("vs_active_1E8", bus.VSYNC, 1'b1);
    do_reset();
    step(1, 0);
    chk("post_rst_vcnt", bus.VCNT, 9'h001);

    // Randomized run: HEND gaps, mode churn and acks, checked every cycle.
    set_mode(0, 0, 0, 0);
    do_reset();
    for (int c = 0; c < 7000; c++) begin
      if ($urandom_range(0, 15) == 0)
        set_mode(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
      if (c == 3500) do_reset();
      step(1'($urandom_range(0, 2) != 0), ($urandom_range(0, 7) == 0));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
